// File: rtl/demux4_stream.sv
// demux4_stream: routes one valid/ready input stream to one of four output
// streams chosen by in_sel. Each output port owns a one-entry holding
// register, so a port can accept a new beat in the same cycle it drains.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   upstream beat present
//   in_data    upstream payload (WIDTH)
//   in_sel     destination port index 0..3
//   in_ready   upstream beat accepted when high together with in_valid
//              (combinational)
//   out_valid  bit k: port k holds a beat
//   out_data   slice [k*WIDTH +: WIDTH] is port k payload
//   out_ready  bit k: port k consumer accepts this cycle
//   out_count  slice [k*CNT_W +: CNT_W] counts beats delivered on port k,
//              wrapping modulo 2^CNT_W
module demux4_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic                 in_ready,
    output logic [3:0]           out_valid,
    output logic [4*WIDTH-1:0]   out_data,
    input  logic [3:0]           out_ready,
    output logic [4*CNT_W-1:0]   out_count
);

    localparam int unsigned NPORT = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    slot_state_t            state_q [NPORT];
    slot_state_t            state_d [NPORT];
    logic [WIDTH-1:0]       data_q  [NPORT];
    logic [CNT_W-1:0]       cnt_q   [NPORT];

    logic                   in_xfer;
    logic [NPORT-1:0]       load;
    logic [NPORT-1:0]       drain;

    // Next-state and handshake decode for all four slots.
    always_comb begin
        in_ready = 1'b0;
        in_xfer  = 1'b0;
        load     = '0;
        drain    = '0;
        for (int k = 0; k < NPORT; k++) begin
            state_d[k] = state_q[k];
        end

        // A full slot can still take a beat if it drains in the same cycle.
        in_ready = ~reset & ((state_q[in_sel] == ST_EMPTY) | out_ready[in_sel]);
        in_xfer  = in_valid & in_ready;

        for (int k = 0; k < NPORT; k++) begin
            load[k]  = in_xfer & (in_sel == 2'(k));
            drain[k] = (state_q[k] == ST_FULL) & out_ready[k];
            // Load wins over drain: simultaneous drain+load keeps the slot full.
            if (load[k]) begin
                state_d[k] = ST_FULL;
            end else if (drain[k]) begin
                state_d[k] = ST_EMPTY;
            end
        end
    end

    // Slot state, payload and delivery counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NPORT; k++) begin
                state_q[k] <= ST_EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                state_q[k] <= state_d[k];
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
                if (drain[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten per-port registers onto the output buses.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_count = '0;
        for (int k = 0; k < NPORT; k++) begin
            out_valid[k]                = (state_q[k] == ST_FULL);
            out_data[k*WIDTH +: WIDTH]  = data_q[k];
            out_count[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

endmodule

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per beat.
REQ-002 Parameter: CNT_W, default 8, width of each per-port transfer counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: in_valid  input  1  upstream beat present.
REQ-006 Port: in_data  input  WIDTH  upstream beat payload.
REQ-007 Port: in_sel  input  2  destination port index (0..3) of current beat.
REQ-008 Port: in_ready  output  1  upstream beat accepted this cycle when high with in_valid.
REQ-009 Port: out_valid  output  4  bit k: port k holds a beat.
REQ-010 Port: out_data  output  4*WIDTH  slice [k*WIDTH +: WIDTH] is port k payload.
REQ-011 Port: out_ready  input  4  bit k: port k consumer accepts this cycle.
REQ-012 Port: out_count  output  4*CNT_W  slice [k*CNT_W +: CNT_W] is number of beats delivered on port k, modulo 2^CNT_W.

Function
REQ-013 Block SHALL be the inverse of the team's 4:1 mux: one input stream routed to one of four output streams by in_sel.
REQ-014 Each port k SHALL own a one-entry holding register (valid bit + WIDTH data); two states per port: EMPTY, FULL.
REQ-015 Transfer on input SHALL occur when in_valid && in_ready; transfer on port k when out_valid[k] && out_ready[k].
REQ-016 in_ready SHALL equal (port in_sel EMPTY) || (out_ready[in_sel]); combinational, depends only on in_sel, slot state, out_ready[in_sel].
REQ-017 in_ready SHALL NOT depend on in_valid.
REQ-018 Port k EMPTY -> FULL on input transfer with in_sel==k; in_data captured; out_valid[k] high the next cycle (latency 1).
REQ-019 Port k FULL -> EMPTY on port-k transfer with no simultaneous input transfer to k.
REQ-020 Port k FULL, simultaneous port-k transfer and input transfer to k: stays FULL, new in_data replaces old; sustained throughput 1 beat/cycle per port.
REQ-021 While out_valid[k] high and out_ready[k] low, out_data slice k and out_valid[k] SHALL hold stable.
REQ-022 Ports not selected by in_sel SHALL be unaffected by input activity; all four ports may drain in the same cycle.
REQ-023 in_sel and in_data SHALL be ignored when in_valid low; no state change.
REQ-024 out_count[k] SHALL increment by 1 on each port-k transfer, wrapping 2^CNT_W-1 -> 0 with no flag.
REQ-025 out_data slice k SHALL hold last captured value when EMPTY (not cleared except by reset).
REQ-026 No beat SHALL be duplicated, dropped, or reordered per port outside of reset.

Reset
REQ-027 While reset high: out_valid = 4'b0000, out_data = 0, out_count = 0, all ports EMPTY.
REQ-028 in_ready SHALL be driven low while reset high; no input transfer recorded.
REQ-029 Reset asserted mid-operation SHALL discard all held beats; first cycle after release all ports EMPTY, in_ready = 1.
REQ-030 out_ready and in_valid during reset SHALL have no effect, including on counters.

Verification
REQ-031 Reset, then in_valid=1, in_sel=2, in_data=8'hA5, out_ready=4'b0000 -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5; following cycle with same in_sel, in_ready=0.
REQ-032 Port 1 FULL with 8'h11, out_ready[1]=1, in_valid=1, in_sel=1, in_data=8'h22 -> in_ready=1; next cycle out_valid[1]=1, out_data[15:8]=8'h22, out_count[15:8]=1.
REQ-033 Round-robin in_sel 0,1,2,3 for 4 cycles, out_ready=4'b1111, data 8'h00..8'h03 -> each port shows its beat exactly one cycle later; each out_count slice = 1.
REQ-034 Port 3 FULL, out_ready[3]=0 for 5 cycles -> out_data[31:24] and out_valid[3] stable; beats to ports 0-2 still accepted, in_ready=1 for them.
REQ-035 Drive 256 beats to port 0 with out_ready[0]=1 -> out_count[7:0] wraps to 0; no other counter changes.
REQ-036 Ports 0 and 2 FULL, assert reset 1 cycle -> out_valid=0, all counters 0, in_ready=1 the cycle after release.
